// File: rtl/msrv32_ctrl_pkg.sv
// Shared encodings for the msrv32 machine-mode trap sequencer:
// FSM states, next-PC select codes, trap cause codes and SYSTEM decode fields.
package msrv32_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RESET       = 2'b00,
        ST_OPERATING   = 2'b01,
        ST_TRAP_TAKEN  = 2'b10,
        ST_TRAP_RETURN = 2'b11
    } state_t;

    localparam int unsigned PC_SRC_W = 2;
    localparam int unsigned CAUSE_W  = 4;

    localparam logic [PC_SRC_W-1:0] PC_BOOT = 2'b00;
    localparam logic [PC_SRC_W-1:0] PC_EPC  = 2'b01;
    localparam logic [PC_SRC_W-1:0] PC_TRAP = 2'b10;
    localparam logic [PC_SRC_W-1:0] PC_NEXT = 2'b11;

    localparam logic [CAUSE_W-1:0] CAUSE_INSTR_MISALIGNED = 4'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL_INSTR    = 4'd2;
    localparam logic [CAUSE_W-1:0] CAUSE_BREAKPOINT       = 4'd3;
    localparam logic [CAUSE_W-1:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [CAUSE_W-1:0] CAUSE_STORE_MISALIGNED = 4'd6;
    localparam logic [CAUSE_W-1:0] CAUSE_ECALL_M          = 4'd11;
    localparam logic [CAUSE_W-1:0] CAUSE_M_SW_INT         = 4'd3;
    localparam logic [CAUSE_W-1:0] CAUSE_M_TIMER_INT      = 4'd7;
    localparam logic [CAUSE_W-1:0] CAUSE_M_EXT_INT        = 4'd11;

    localparam logic [4:0] OPCODE_SYSTEM = 5'b11100;
    localparam logic [6:0] FUNCT7_MRET   = 7'b0011000;
    localparam logic [4:0] RS2_MRET      = 5'b00010;

endpackage

// File: rtl/msrv32_trap_priority.sv
// Combinational trap priority encoder.
// Inputs : decoded exception flags, mstatus.MIE, per-source enables/pendings.
// Outputs: o_trap (any trap), o_cause (cause code), o_i_or_e (1 = interrupt).
// Exceptions always win over interrupts.
module msrv32_trap_priority
    import msrv32_ctrl_pkg::*;
(
    input  logic               i_misaligned_instr,
    input  logic               i_illegal,
    input  logic               i_ebreak,
    input  logic               i_ecall,
    input  logic               i_misaligned_load,
    input  logic               i_misaligned_store,
    input  logic               i_mie,
    input  logic               i_meie,
    input  logic               i_mtie,
    input  logic               i_msie,
    input  logic               i_meip,
    input  logic               i_mtip,
    input  logic               i_msip,
    output logic               o_trap,
    output logic [CAUSE_W-1:0] o_cause,
    output logic               o_i_or_e
);

    logic w_ext_int;
    logic w_sw_int;
    logic w_tmr_int;

    assign w_ext_int = i_mie & i_meie & i_meip;
    assign w_sw_int  = i_mie & i_msie & i_msip;
    assign w_tmr_int = i_mie & i_mtie & i_mtip;

    // Priority chain, highest first.
    always_comb begin
        o_trap   = 1'b1;
        o_i_or_e = 1'b0;
        o_cause  = CAUSE_INSTR_MISALIGNED;
        if (i_misaligned_instr) begin
            o_cause = CAUSE_INSTR_MISALIGNED;
        end else if (i_illegal) begin
            o_cause = CAUSE_ILLEGAL_INSTR;
        end else if (i_ebreak) begin
            o_cause = CAUSE_BREAKPOINT;
        end else if (i_ecall) begin
            o_cause = CAUSE_ECALL_M;
        end else if (i_misaligned_load) begin
            o_cause = CAUSE_LOAD_MISALIGNED;
        end else if (i_misaligned_store) begin
            o_cause = CAUSE_STORE_MISALIGNED;
        end else if (w_ext_int) begin
            o_i_or_e = 1'b1;
            o_cause  = CAUSE_M_EXT_INT;
        end else if (w_sw_int) begin
            o_i_or_e = 1'b1;
            o_cause  = CAUSE_M_SW_INT;
        end else if (w_tmr_int) begin
            o_i_or_e = 1'b1;
            o_cause  = CAUSE_M_TIMER_INT;
        end else begin
            o_trap  = 1'b0;
        end
    end

endmodule

// File: rtl/msrv32_machine_control.sv
// Machine-mode trap sequencer: decodes exceptions, interrupts and MRET from
// execute, drives the CSR file trap strobes, selects the next PC and flushes.
// Inputs : clock, rst_in (async active-low), instruction fields, decoder
//          flags, mstatus.MIE, interrupt enables and pendings.
// Outputs: CSR strobes (set_epc/set_cause/mie_clear/mie_set/instret_inc/
//          misaligned_exception), cause/i_or_e, pc_src, flush, trap_taken.
// Detection-cycle outputs are Mealy; cause/i_or_e are latched at that edge.
module msrv32_machine_control
    import msrv32_ctrl_pkg::*;
(
    input  logic                clock,
    input  logic                rst_in,
    input  logic [4:0]          opcode_6_to_2_in,
    input  logic [2:0]          funct3_in,
    input  logic [6:0]          funct7_in,
    input  logic [4:0]          rs1_addr_in,
    input  logic [4:0]          rs2_addr_in,
    input  logic [4:0]          rd_addr_in,
    input  logic                illegal_instr_in,
    input  logic                misaligned_instr_in,
    input  logic                misaligned_load_in,
    input  logic                misaligned_store_in,
    input  logic                mie_in,
    input  logic                meie_in,
    input  logic                mtie_in,
    input  logic                msie_in,
    input  logic                meip_in,
    input  logic                mtip_in,
    input  logic                msip_in,
    output logic                i_or_e_out,
    output logic [CAUSE_W-1:0]  cause_out,
    output logic                set_cause_out,
    output logic                set_epc_out,
    output logic                instret_inc_out,
    output logic                mie_clear_out,
    output logic                mie_set_out,
    output logic                misaligned_exception_out,
    output logic [PC_SRC_W-1:0] pc_src_out,
    output logic                flush_out,
    output logic                trap_taken_out
);

    state_t             r_state;
    state_t             w_next_state;
    logic [CAUSE_W-1:0] r_cause;
    logic               r_i_or_e;

    logic               w_system;
    logic               w_ecall;
    logic               w_ebreak;
    logic               w_mret;
    logic               w_trap;
    logic [CAUSE_W-1:0] w_cause;
    logic               w_i_or_e;
    logic               w_trap_now;

    // SYSTEM-instruction decode.
    assign w_system = (opcode_6_to_2_in == OPCODE_SYSTEM) && (funct3_in == 3'b000)
                   && (rs1_addr_in == 5'd0) && (rd_addr_in == 5'd0);
    assign w_ecall  = w_system && (funct7_in == 7'd0) && (rs2_addr_in == 5'd0);
    assign w_ebreak = w_system && (funct7_in == 7'd0) && (rs2_addr_in == 5'd1);
    assign w_mret   = w_system && (funct7_in == FUNCT7_MRET) && (rs2_addr_in == RS2_MRET);

    msrv32_trap_priority u_trap_priority (
        .i_misaligned_instr (misaligned_instr_in),
        .i_illegal          (illegal_instr_in),
        .i_ebreak           (w_ebreak),
        .i_ecall            (w_ecall),
        .i_misaligned_load  (misaligned_load_in),
        .i_misaligned_store (misaligned_store_in),
        .i_mie              (mie_in),
        .i_meie             (meie_in),
        .i_mtie             (mtie_in),
        .i_msie             (msie_in),
        .i_meip             (meip_in),
        .i_mtip             (mtip_in),
        .i_msip             (msip_in),
        .o_trap             (w_trap),
        .o_cause            (w_cause),
        .o_i_or_e           (w_i_or_e)
    );

    // Traps are only honoured while operating.
    assign w_trap_now = (r_state == ST_OPERATING) && w_trap;

    // State register.
    always_ff @(posedge clock or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Latched cause / i_or_e, captured on the detection edge.
    always_ff @(posedge clock or negedge rst_in) begin
        if (!rst_in) begin
            r_cause  <= '0;
            r_i_or_e <= 1'b0;
        end else if (w_trap_now) begin
            r_cause  <= w_cause;
            r_i_or_e <= w_i_or_e;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = ST_OPERATING;
        case (r_state)
            ST_OPERATING: begin
                if (w_trap) begin
                    w_next_state = ST_TRAP_TAKEN;
                end else if (w_mret) begin
                    w_next_state = ST_TRAP_RETURN;
                end else begin
                    w_next_state = ST_OPERATING;
                end
            end
            default: w_next_state = ST_OPERATING;
        endcase
    end

    // Output logic.
    always_comb begin
        pc_src_out      = PC_BOOT;
        flush_out       = 1'b0;
        trap_taken_out  = 1'b0;
        set_epc_out     = 1'b0;
        set_cause_out   = 1'b0;
        instret_inc_out = 1'b0;
        mie_clear_out   = 1'b0;
        mie_set_out     = 1'b0;
        cause_out       = r_cause;
        i_or_e_out      = r_i_or_e;
        case (r_state)
            ST_RESET: begin
                pc_src_out = PC_BOOT;
                flush_out  = 1'b1;
            end
            ST_OPERATING: begin
                pc_src_out = PC_NEXT;
                if (w_trap) begin
                    trap_taken_out = 1'b1;
                    set_epc_out    = 1'b1;
                    set_cause_out  = 1'b1;
                    cause_out      = w_cause;
                    i_or_e_out     = w_i_or_e;
                end else begin
                    instret_inc_out = 1'b1;
                end
            end
            ST_TRAP_TAKEN: begin
                pc_src_out    = PC_TRAP;
                mie_clear_out = 1'b1;
                flush_out     = 1'b1;
            end
            ST_TRAP_RETURN: begin
                pc_src_out  = PC_EPC;
                mie_set_out = 1'b1;
                flush_out   = 1'b1;
            end
            default: begin
                pc_src_out = PC_BOOT;
                flush_out  = 1'b1;
            end
        endcase
    end

    // mtval load from iadder only for address-misalignment exceptions.
    assign misaligned_exception_out = w_trap_now && !w_i_or_e
        && ((w_cause == CAUSE_INSTR_MISALIGNED) || (w_cause == CAUSE_LOAD_MISALIGNED)
         || (w_cause == CAUSE_STORE_MISALIGNED));

endmodule

// File: tb/tb_msrv32_machine_control.sv
// Self-checking bench for msrv32_machine_control: directed steps followed by
// randomized cycles, compared against a behavioural model of the trap rules.
module tb_msrv32_machine_control;

    logic       clock;
    logic       rst_in;
    logic [4:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1, rs2, rd;
    logic       illegal, mis_i, mis_l, mis_s;
    logic       mie, meie, mtie, msie, meip, mtip, msip;

    logic       i_or_e_out;
    logic [3:0] cause_out;
    logic       set_cause_out, set_epc_out, instret_inc_out;
    logic       mie_clear_out, mie_set_out, misaligned_exception_out;
    logic [1:0] pc_src_out;
    logic       flush_out, trap_taken_out;

    int total = 0;
    int bad   = 0;

    // Model: phase 0 = booting, 1 = running, 2 = entering handler, 3 = returning.
    int         m_phase = 0;
    logic [3:0] m_cause = 4'd0;
    bit         m_ie    = 1'b0;

    msrv32_machine_control dut (
        .clock                    (clock),
        .rst_in                   (rst_in),
        .opcode_6_to_2_in         (opcode),
        .funct3_in                (funct3),
        .funct7_in                (funct7),
        .rs1_addr_in              (rs1),
        .rs2_addr_in              (rs2),
        .rd_addr_in               (rd),
        .illegal_instr_in         (illegal),
        .misaligned_instr_in      (mis_i),
        .misaligned_load_in       (mis_l),
        .misaligned_store_in      (mis_s),
        .mie_in                   (mie),
        .meie_in                  (meie),
        .mtie_in                  (mtie),
        .msie_in                  (msie),
        .meip_in                  (meip),
        .mtip_in                  (mtip),
        .msip_in                  (msip),
        .i_or_e_out               (i_or_e_out),
        .cause_out                (cause_out),
        .set_cause_out            (set_cause_out),
        .set_epc_out              (set_epc_out),
        .instret_inc_out          (instret_inc_out),
        .mie_clear_out            (mie_clear_out),
        .mie_set_out              (mie_set_out),
        .misaligned_exception_out (misaligned_exception_out),
        .pc_src_out               (pc_src_out),
        .flush_out                (flush_out),
        .trap_taken_out           (trap_taken_out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_sys();
        return opcode == 5'b11100 && funct3 == 3'd0 && rs1 == 5'd0 && rd == 5'd0;
    endfunction

    function automatic bit is_mret();
        return is_sys() && funct7 == 7'b0011000 && rs2 == 5'd2;
    endfunction

    // Reference trap decision: first hit in a priority-ordered list.
    function automatic void ref_trap(output bit trap, output bit ie, output logic [3:0] cause);
        bit ex [6];
        int ex_code [6];
        bit ip [3];
        int ip_code [3];
        ex      = '{mis_i, illegal, is_sys() && funct7 == 0 && rs2 == 1,
                    is_sys() && funct7 == 0 && rs2 == 0, mis_l, mis_s};
        ex_code = '{0, 2, 3, 11, 4, 6};
        ip      = '{mie & meie & meip, mie & msie & msip, mie & mtie & mtip};
        ip_code = '{11, 3, 7};
        trap = 1'b0; ie = 1'b0; cause = 4'd0;
        for (int i = 0; i < 6; i++) begin
            if (!trap && ex[i]) begin
                trap = 1'b1; cause = 4'(ex_code[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (!trap && ip[i]) begin
                trap = 1'b1; ie = 1'b1; cause = 4'(ip_code[i]);
            end
        end
    endfunction

    task automatic clear_inputs();
        opcode = 5'b01100; funct3 = 3'd0; funct7 = 7'd0;
        rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3;
        illegal = 0; mis_i = 0; mis_l = 0; mis_s = 0;
        mie = 0; meie = 0; mtie = 0; msie = 0; meip = 0; mtip = 0; msip = 0;
    endtask

    // kind: 0 random fields, 1 ECALL, 2 EBREAK, 3 MRET
    task automatic set_instr(input int kind);
        if (kind == 0) begin
            opcode = 5'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
            rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
        end else begin
            opcode = 5'b11100; funct3 = 3'd0; rs1 = 5'd0; rd = 5'd0;
            funct7 = (kind == 3) ? 7'b0011000 : 7'd0;
            rs2    = (kind == 1) ? 5'd0 : ((kind == 2) ? 5'd1 : 5'd2);
        end
    endtask

    // Check one cycle at the falling edge, then advance the model past the rising edge.
    task automatic cycle();
        bit         trap, ie, misal;
        logic [3:0] cs;
        logic [1:0] e_pc;
        bit         e_flush, e_tt, e_epc, e_scause, e_inst, e_mclr, e_mset, e_ie;
        logic [3:0] e_cause;
        int         nphase;
        logic [3:0] ncause;
        bit         nie;
        @(negedge clock);
        ref_trap(trap, ie, cs);
        misal = 0; e_tt = 0; e_epc = 0; e_scause = 0; e_inst = 0; e_mclr = 0; e_mset = 0;
        e_flush = 1; e_pc = 2'b00; e_cause = m_cause; e_ie = m_ie;
        nphase = 1; ncause = m_cause; nie = m_ie;
        case (m_phase)
            1: begin
                e_pc = 2'b11; e_flush = 0;
                if (trap) begin
                    e_tt = 1; e_epc = 1; e_scause = 1; e_cause = cs; e_ie = ie;
                    misal = !ie && (cs == 0 || cs == 4 || cs == 6);
                    nphase = 2; ncause = cs; nie = ie;
                end else begin
                    e_inst = 1;
                    nphase = is_mret() ? 3 : 1;
                end
            end
            2: begin e_pc = 2'b10; e_mclr = 1; end
            3: begin e_pc = 2'b01; e_mset = 1; end
            default: ;
        endcase
        chk("pc_src", 4'(pc_src_out), 4'(e_pc));
        chk("flush", 4'(flush_out), 4'(e_flush));
        chk("trap_taken", 4'(trap_taken_out), 4'(e_tt));
        chk("set_epc", 4'(set_epc_out), 4'(e_epc));
        chk("set_cause", 4'(set_cause_out), 4'(e_scause));
        chk("instret_inc", 4'(instret_inc_out), 4'(e_inst));
        chk("mie_clear", 4'(mie_clear_out), 4'(e_mclr));
        chk("mie_set", 4'(mie_set_out), 4'(e_mset));
        chk("cause", cause_out, e_cause);
        chk("i_or_e", 4'(i_or_e_out), 4'(e_ie));
        chk("misaligned_exc", 4'(misaligned_exception_out), 4'(misal));
        @(posedge clock);
        #1;
        if (!rst_in) begin
            m_phase = 0; m_cause = 4'd0; m_ie = 1'b0;
        end else begin
            m_phase = nphase; m_cause = ncause; m_ie = nie;
        end
    endtask

    initial begin
        rst_in = 1'b0;
        clear_inputs();
        // Held in reset.
        cycle();
        cycle();
        rst_in = 1'b1;
        // One boot cycle, then normal fetch.
        cycle();
        cycle();
        // ECALL and its handler entry.
        set_instr(1); cycle();
        clear_inputs(); cycle();
        cycle();
        // Software + timer pending: software wins; then globally disabled.
        mie = 1; mtie = 1; mtip = 1; msie = 1; msip = 1; cycle();
        clear_inputs(); cycle();
        mtie = 1; mtip = 1; msie = 1; msip = 1; cycle();
        // Illegal beats misaligned load; load alone flags mtval.
        clear_inputs(); illegal = 1; mis_l = 1; cycle();
        clear_inputs(); cycle();
        mis_l = 1; cycle();
        clear_inputs(); cycle();
        // MRET, then MRET masked by an external interrupt.
        set_instr(3); cycle();
        clear_inputs(); cycle();
        cycle();
        set_instr(3); mie = 1; meie = 1; meip = 1; cycle();
        clear_inputs(); cycle();
        // Reset during TRAP_TAKEN aborts immediately.
        set_instr(1); cycle();
        clear_inputs();
        rst_in = 1'b0;
        #1;
        chk("rst_pc_src", 4'(pc_src_out), 4'd0);
        chk("rst_mie_clear", 4'(mie_clear_out), 4'd0);
        chk("rst_flush", 4'(flush_out), 4'd1);
        chk("rst_cause", cause_out, 4'd0);
        m_phase = 0; m_cause = 4'd0; m_ie = 1'b0;
        cycle();
        rst_in = 1'b1;
        cycle();
        cycle();
        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            set_instr(int'($urandom_range(0, 3)));
            illegal = ($urandom_range(0, 9) == 0);
            mis_i   = ($urandom_range(0, 11) == 0);
            mis_l   = ($urandom_range(0, 9) == 0);
            mis_s   = ($urandom_range(0, 9) == 0);
            mie  = 1'($urandom); meie = 1'($urandom); mtie = 1'($urandom); msie = 1'($urandom);
            meip = ($urandom_range(0, 3) == 0);
            mtip = ($urandom_range(0, 3) == 0);
            msip = ($urandom_range(0, 3) == 0);
            cycle();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/msrv32_machine_control.md
# msrv32_machine_control

Machine-mode trap sequencer for the msrv32 core. It is the initiator side of the CSR trap interface: it decodes exceptions, pending interrupts and MRET from the execute stage, then drives the CSR file's trap controls (set_epc, set_cause, cause, i_or_e, mie_clear, mie_set, instret_inc, misaligned_exception). It also tells the PC mux where to fetch next and flushes the pipeline on every control transfer.

## Interface

Parameters:
- none. All state and PC-source encodings live in the shared package.

Ports:
- clock  in  1  core clock; all state updates on rising edge
- rst_in  in  1  asynchronous, active-low reset
- opcode_6_to_2_in  in  5  instruction bits [6:2]
- funct3_in  in  3  instruction bits [14:12]
- funct7_in  in  7  instruction bits [31:25]
- rs1_addr_in, rs2_addr_in, rd_addr_in  in  5 each  register fields
- illegal_instr_in  in  1  decoder flags an illegal instruction
- misaligned_instr_in, misaligned_load_in, misaligned_store_in  in  1 each  misalignment flags
- mie_in  in  1  mstatus.MIE, the global interrupt enable
- meie_in, mtie_in, msie_in  in  1 each  per-source interrupt enables
- meip_in, mtip_in, msip_in  in  1 each  per-source pending bits
- i_or_e_out  out  1  1 = interrupt, 0 = exception
- cause_out  out  4  cause code
- set_cause_out, set_epc_out  out  1 each  CSR file capture strobes
- instret_inc_out  out  1  instruction retired
- mie_clear_out, mie_set_out  out  1 each  mstatus.MIE control
- misaligned_exception_out  out  1  tells the CSR file to load mtval from iadder
- pc_src_out  out  2  next-PC select: BOOT=00, EPC=01, TRAP=10, NEXT=11
- flush_out  out  1  kill the instruction currently in fetch
- trap_taken_out  out  1  a trap was detected this cycle

## Operation

- States (2-bit): RESET=00, OPERATING=01, TRAP_TAKEN=10, TRAP_RETURN=11.
- Instruction decode:
  - SYSTEM means opcode_6_to_2_in == 11100, funct3_in == 000, rs1_addr_in == 0, rd_addr_in == 0.
  - ECALL: SYSTEM, funct7_in == 0, rs2_addr_in == 0.
  - EBREAK: SYSTEM, funct7_in == 0, rs2_addr_in == 1.
  - MRET: SYSTEM, funct7_in == 0011000, rs2_addr_in == 00010.
- Exception priority, highest first:
  - misaligned_instr: cause 0
  - illegal: cause 2
  - EBREAK: cause 3
  - ECALL: cause 11
  - misaligned_load: cause 4
  - misaligned_store: cause 6
- Interrupt pending is mie_in & (meie&meip | msie&msip | mtie&mtip). Interrupt priority: external (cause 11), then software (3), then timer (7).
- Overall priority is exception > interrupt > MRET.
- OPERATING, trap detected (Mealy, same cycle):
  - trap_taken_out, set_epc_out and set_cause_out are 1.
  - cause_out and i_or_e_out carry the new values, which are latched at the edge.
  - instret_inc_out = 0. Next state is TRAP_TAKEN.
- OPERATING, MRET with no trap: instret_inc_out = 1; next state is TRAP_RETURN.
- OPERATING, otherwise: instret_inc_out = 1, pc_src_out = NEXT, flush_out = 0.
- TRAP_TAKEN: pc_src_out = TRAP, mie_clear_out = 1, flush_out = 1. Next state is OPERATING.
- TRAP_RETURN: pc_src_out = EPC, mie_set_out = 1, flush_out = 1. Next state is OPERATING.
- RESET: pc_src_out = BOOT, flush_out = 1, all strobes 0. Next state is OPERATING unconditionally.
- Outside a detection cycle, cause_out and i_or_e_out show the last latched values.
- misaligned_exception_out is 1 only when trap_taken_out = 1, i_or_e_out = 0 and cause_out is 0, 4 or 6.
- In TRAP_TAKEN, TRAP_RETURN and RESET, trap and MRET inputs are ignored; no strobes are raised.

## Timing

- Reset values, asserted immediately while rst_in = 0:
  - state = RESET, pc_src_out = 00, flush_out = 1.
  - latched cause = 0, latched i_or_e = 0.
  - All other outputs 0.
- Reset deassertion: RESET is held for exactly one cycle, then OPERATING.
- Trap latency:
  - Detection cycle: strobes asserted.
  - Next cycle: pc_src = TRAP, mie_clear and flush asserted.
  - Cycle after that: back in OPERATING.
- MRET latency: one cycle to TRAP_RETURN, then OPERATING.
- Reset asserted in TRAP_TAKEN or TRAP_RETURN aborts the sequence. mie_clear and mie_set drop immediately.
- An interrupt whose pending bit drops before a cycle in OPERATING is not taken; there is no internal latching of pending bits.

## Structure

- Package msrv32_ctrl_pkg holds:
  - state encodings
  - PC_SRC codes BOOT, EPC, TRAP, NEXT
  - cause constants 0, 2, 3, 4, 6, 7, 11
  - SYSTEM opcode, MRET funct7, MRET rs2
- One sub-module, msrv32_trap_priority: a combinational priority encoder that takes the decoded flags and enable/pending bits and returns a trap flag, the cause and i_or_e. The FSM and output registers stay in the top level.

## Test plan

- Reset release, no events → one cycle with pc_src = 00 and flush = 1, then pc_src = 11 with flush = 0.
- ECALL in OPERATING → set_epc = set_cause = 1, cause = 11, i_or_e = 0. Next cycle pc_src = 10, mie_clear = 1. instret_inc = 0 in the detection cycle.
- mie_in = 1, mtie = mtip = 1 and msie = msip = 1 → cause = 3, i_or_e = 1. Repeat with mie_in = 0 → no trap, instret_inc = 1.
- misaligned_load and illegal asserted together → cause = 2, misaligned_exception_out = 0. misaligned_load alone → cause = 4, misaligned_exception_out = 1.
- MRET, then MRET together with meip = meie = mie = 1 → first: TRAP_RETURN with pc_src = 01 and mie_set = 1. Second: interrupt with cause 11, no TRAP_RETURN.
- rst_in pulled low during TRAP_TAKEN → mie_clear = 0 and pc_src = 00 immediately, latched cause = 0.
